// File: rtl/mips_mem_pkg.sv
// Shared widths and encodings for the unified instruction/data memory port.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    MODE_RUN,
    MODE_LOAD
  } mode_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_IF,
    SEL_DM,
    SEL_LD
  } port_sel_e;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive cycles the fetch port loses to the data port; saturates at STARVE_MAX.
module starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk1,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] r_cnt;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_max = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between fetch, data access and the halted-core loader.
//   mode      | meaning
//   MODE_RUN  | IF and DM compete, DM first unless IF has starved STARVE_MAX cycles
//   MODE_LOAD | core halted, only the loader is served
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  mode_e     r_mode;
  mode_e     w_mode_nxt;
  port_sel_e w_sel;
  logic      w_starve_max;
  logic      r_if_rvalid;
  logic      r_dm_rvalid;
  logic      r_ld_rvalid;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_RUN;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // Leaving RUN only in an idle cycle keeps a read from being granted as LOAD begins.
  always_comb begin
    w_mode_nxt = r_mode;
    w_sel      = SEL_NONE;
    if (!rst) begin
      case (r_mode)
        MODE_RUN: begin
          if (dm_req && !(if_req && w_starve_max)) begin
            w_sel = SEL_DM;
          end else if (if_req) begin
            w_sel = SEL_IF;
          end
          if (halted && (w_sel == SEL_NONE)) begin
            w_mode_nxt = MODE_LOAD;
          end
        end
        MODE_LOAD: begin
          if (ld_req) begin
            w_sel = SEL_LD;
          end
          if (!halted && !ld_req) begin
            w_mode_nxt = MODE_RUN;
          end
        end
        default: w_mode_nxt = MODE_RUN;
      endcase
    end
  end

  assign if_gnt = (w_sel == SEL_IF);
  assign dm_gnt = (w_sel == SEL_DM);
  assign ld_gnt = (w_sel == SEL_LD);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_sel)
      SEL_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      SEL_DM: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      SEL_LD: begin
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      default: ;
    endcase
  end

  starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk1    (clk1),
    .rst     (rst),
    .i_inc   (if_req && dm_gnt),
    .i_clr   (if_gnt || !if_req),
    .o_at_max(w_starve_max)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_ld_rvalid <= 1'b0;
    end else begin
      r_if_rvalid <= if_gnt;
      r_dm_rvalid <= dm_gnt && !dm_we;
      r_ld_rvalid <= ld_gnt && !ld_we;
    end
  end

  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign ld_rvalid = r_ld_rvalid;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign ld_rdata  = mem_rdata;

endmodule
